shift_sequencer: RTL and testbench

- Multi-cycle shift unit controller for the 32-bit ALU.
- Sequences a single shared fixed-stage shift datapath (stages 16, 8, 4, 2, 1) across successive cycles instead of building a full combinational barrel shifter.
- Each cycle it applies at most one stage, selected by one bit of the shift amount, and handshakes the result back to the pipeline with a one-cycle ready pulse.
- Supports logical left, arithmetic right and logical right shifts.

---
 rtl/shift_sequencer.sv | 105 ++++++++++
 tb/tb_shift_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller for the 32-bit ALU.
// One shared set of fixed-distance shift stages (2**k for k = SHAMT_W-1 .. 0)
// is applied one stage per clock, largest distance first. Each stage is
// selected by one bit of the latched shift amount. The latency is fixed, and
// the result is announced with a one-cycle data_resultRDY pulse.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         shift_op,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  // Stage counter must hold SHAMT_W-1; keep at least one bit for tiny configs.
  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic [1:0]         op_reg;
  logic               sign_reg;

  // Candidate value for every stage; only the one addressed by the counter is used.
  logic [WIDTH-1:0]   stage_val [SHAMT_W];
  logic [WIDTH-1:0]   work_next;

  // Fixed-distance shifters, one per stage. 01 = sra, 10 = srl, 00/11 = sll.
  // sra fills from the sign bit latched at capture, so the fill stays the
  // same through every stage.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int SH = 2 ** gi;
      assign stage_val[gi] =
        (op_reg == 2'b01) ? ((work_reg >> SH) | ({WIDTH{sign_reg}} << (WIDTH - SH))) :
        (op_reg == 2'b10) ? (work_reg >> SH) :
                            (work_reg << SH);
    end
  endgenerate

  // Apply the current stage only when its shift-amount bit is set.
  assign work_next = shamt_reg[cnt_reg] ? stage_val[cnt_reg] : work_reg;

  // Control FSM with registered outputs. An operation is accepted in IDLE or
  // DONE, runs SHAMT_W SHIFT cycles, and then pulses RDY for one cycle in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      work_reg       <= '0;
      shamt_reg      <= '0;
      op_reg         <= '0;
      sign_reg       <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (ctrl_shift) begin
            work_reg  <= data_operand;
            shamt_reg <= shamt;
            op_reg    <= shift_op;
            sign_reg  <= data_operand[WIDTH-1];
            cnt_reg   <= CNT_W'(SHAMT_W - 1);
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          work_reg <= work_next;
          if (cnt_reg == '0) begin
            data_result    <= work_next;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state_reg      <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer.
// The reference model uses plain SystemVerilog shift operators. Cycle timing
// is checked against the fixed latency: busy in cycles 1..5, RDY only in cycle 6.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_shift = 1'b0;
  logic [31:0] data_operand = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  shift_op = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_result = '0;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .data_operand   (data_operand),
    .shamt          (shamt),
    .shift_op       (shift_op),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                            input logic [4:0] s);
    case (op)
      2'b01:   return 32'($signed(x) >>> s);
      2'b10:   return x >> s;
      default: return x << s;
    endcase
  endfunction

  task automatic scramble();
    data_operand = $urandom;
    shamt        = 5'($urandom);
    shift_op     = 2'($urandom);
  endtask

  // Present an operation and let the next rising edge capture it. The task
  // returns #1 into cycle 1 with ctrl_shift low and the inputs scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [4:0] s);
    shift_op     = op;
    data_operand = x;
    shamt        = s;
    ctrl_shift   = 1'b1;
    @(posedge clock);
    #1;
    ctrl_shift = 1'b0;
    scramble();
  endtask

  // Follow one operation from cycle 1 to cycle 8, or to cycle 6 when chaining.
  // mid: pulse ctrl_shift with junk data during cycles 2..4.
  // chain: hold ctrl_shift high during DONE with the next operation's inputs.
  task automatic watch(input logic [31:0] expv, input bit mid, input bit chain,
                       input logic [1:0] nop, input logic [31:0] nx, input logic [4:0] nsh,
                       input string name);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      checks++;
      if (busy !== (c <= 5)) begin
        failures++;
        $display("FAIL %s busy cycle=%0d got=%b exp=%b", name, c, busy, (c <= 5));
      end
      checks++;
      if (data_resultRDY !== (c == 6)) begin
        failures++;
        $display("FAIL %s rdy cycle=%0d got=%b exp=%b", name, c, data_resultRDY, (c == 6));
      end
      checks++;
      if (c <= 5) begin
        if (data_result !== last_result) begin
          failures++;
          $display("FAIL %s hold cycle=%0d got=%h exp=%h", name, c, data_result, last_result);
        end
      end else begin
        if (data_result !== expv) begin
          failures++;
          $display("FAIL %s result cycle=%0d got=%h exp=%h", name, c, data_result, expv);
        end
      end
      if (c == 6) begin
        $display("op %s result=%h expected=%h", name, data_result, expv);
        last_result = expv;
      end
      if (c == 8) break;
      if (chain && c == 6) begin
        @(posedge clock);
        #1;
        ctrl_shift = 1'b0;
        scramble();
        break;
      end
      @(posedge clock);
      #1;
      ctrl_shift = 1'b0;
      if (mid && (c + 1 >= 2) && (c + 1 <= 4)) begin
        scramble();
        ctrl_shift = 1'b1;
      end
      if (chain && (c + 1 == 6)) begin
        shift_op     = nop;
        data_operand = nx;
        shamt        = nsh;
        ctrl_shift   = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (data_result !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h/%b/%b exp=00000000/0/0", data_result, busy, data_resultRDY);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (data_result !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset got=%h/%b/%b exp=00000000/0/0",
                 data_result, busy, data_resultRDY);
      end
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [31:0] xs  [8] = '{32'h80000000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hF0000000};
    logic [4:0]  ss  [8] = '{5'd8, 5'd8, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd31};
    logic [31:0] es  [8] = '{32'hFF800000, 32'h00800000, 32'h80000000, 32'h00000000,
                             32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], xs[i], ss[i]);
      watch(es[i], 1'b0, 1'b0, 2'b00, 32'h0, 5'd0, $sformatf("directed%0d", i));
    end
  endtask

  task automatic test_reserved();
    issue(2'b11, 32'h00000003, 5'd4);
    watch(32'h00000030, 1'b0, 1'b0, 2'b00, 32'h0, 5'd0, "reserved");
  endtask

  task automatic test_ignore_mid();
    issue(2'b01, 32'h80000001, 5'd3);
    watch(32'hF0000000, 1'b1, 1'b0, 2'b00, 32'h0, 5'd0, "ignore_mid");
  endtask

  task automatic test_back_to_back();
    issue(2'b10, 32'hFFFF0000, 5'd16);
    watch(32'h0000FFFF, 1'b0, 1'b1, 2'b00, 32'h0000ABCD, 5'd12, "b2b_first");
    watch(32'h0ABCD000, 1'b0, 1'b0, 2'b00, 32'h0, 5'd0, "b2b_second");
  endtask

  task automatic test_async_reset();
    issue(2'b10, 32'h12345678, 5'd4);
    watch(32'h01234567, 1'b0, 1'b0, 2'b00, 32'h0, 5'd0, "pre_abort");
    issue(2'b00, 32'h0000FFFF, 5'd8);
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (data_result !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b exp=00000000/0/0", data_result, busy, data_resultRDY);
    end
    last_result = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'h0) begin
        failures++;
        $display("FAIL post_abort cycle=%0d got=%h/%b/%b exp=00000000/0/0",
                 i, data_result, busy, data_resultRDY);
      end
    end
    issue(2'b01, 32'h80000000, 5'd4);
    watch(32'hF8000000, 1'b0, 1'b0, 2'b00, 32'h0, 5'd0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op1, op2;
      logic [31:0] x1, x2;
      logic [4:0]  s1, s2;
      bit          mid, chain;
      op1   = 2'($urandom);
      x1    = $urandom;
      s1    = 5'($urandom);
      op2   = 2'($urandom);
      x2    = $urandom;
      s2    = 5'($urandom);
      mid   = 1'($urandom_range(0, 1));
      chain = ($urandom_range(0, 3) == 0);
      issue(op1, x1, s1);
      watch(ref_shift(op1, x1, s1), mid, chain, op2, x2, s2, $sformatf("rand%0d", i));
      if (chain)
        watch(ref_shift(op2, x2, s2), 1'b0, 1'b0, 2'b00, 32'h0, 5'd0,
              $sformatf("rand%0d_chained", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reserved();
    test_ignore_mid();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
